// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// FSM state encoding, statistics counter width and index-width function.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above start, then wrapping below it.
// Zero latency; no backpressure, pure function of its inputs.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] start_i,
    output logic          found_o,
    output logic [N-1:0]  pick_o
);

    // Two passes over constant indices keep the search free of variable bit selects.
    always_comb begin
        found_o = 1'b0;
        pick_o  = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_o && req_i[i] && (i >= int'(start_i))) begin
                found_o   = 1'b1;
                pick_o[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_o && req_i[i] && (i < int'(start_i))) begin
                found_o   = 1'b1;
                pick_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers, bounded bursts.
// One cycle arbitration latency from IDLE, back-to-back re-grant; fifo_full stalls the owner. Option: FIFO_ARB_STATS_EN.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_w_en,
    output logic [DATA_WIDTH-1:0]       fifo_w_data,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]     stat_count
`endif
);

    localparam int PW = idx_width(N_REQ);
    localparam int CW = idx_width(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

    logic [PW-1:0]         g_idx;
    logic [PW-1:0]         next_ptr;
    logic [PW-1:0]         pick_start;
    logic                  pick_found;
    logic [N_REQ-1:0]      pick_onehot;
    logic                  owner_valid;
    logic                  accept;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] w_data_c;

    always_comb begin
        g_idx    = '0;
        w_data_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx = PW'(i);
            end
            w_data_c = w_data_c | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
    end

    assign next_ptr    = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
    assign owner_valid = |(grant_q & req_valid);
    assign accept      = (state_q == BURST) && owner_valid && !fifo_full;
    assign burst_end   = (accept && (burst_cnt_q == CW'(MAX_BURST - 1))) || !owner_valid;

    // IDLE searches from the stored pointer; BURST pre-computes the post-rotation search.
    assign pick_start = (state_q == BURST) ? next_ptr : rr_ptr_q;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i   (req_valid),
        .start_i (pick_start),
        .found_o (pick_found),
        .pick_o  (pick_onehot)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_onehot;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if (burst_end) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick_onehot;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign req_ready   = grant_q & {N_REQ{!fifo_full}};
    assign fifo_w_en   = accept;
    assign fifo_w_data = w_data_c;
    assign grant       = grant_q;
    assign busy        = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
        logic [STAT_W-1:0] stat_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_q <= '0;
            end else if (accept && grant_q[gi] && (stat_q != {STAT_W{1'b1}})) begin
                stat_q <= stat_q + 1'b1;
            end
        end

        assign stat_count[gi*STAT_W +: STAT_W] = stat_q;
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed plus randomized bench for fifo_write_arbiter against a transaction-level arbitration model.
module tb_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_w_data;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] stat_count;
`endif

    fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data),
        .grant       (grant),
        .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_count  (stat_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 = none), words sent in this burst, next search start.
    int m_owner, m_words, m_ptr;
    int m_acc [N];
    int dut_w [N];
    int seq [N];
    int left [N];
    logic [N-1:0] en;
    bit rnd_mode = 0;
    int run_len, max_run;
    logic [N-1:0] prev_g;
    logic [N-1:0] order_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr_first(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_words = 0;
        m_ptr   = 0;
        run_len = 0;
        max_run = 0;
        prev_g  = '0;
        order_q.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (left[i] > 0);
            req_data[i*DW +: DW] = DW'((i << 5) | (seq[i] & 31));
        end
    endtask

    // One clock: check outputs against the model, cross the edge, then advance the model.
    task automatic step();
        logic [N-1:0]  eg;
        logic [N-1:0]  vv;
        logic [DW-1:0] ed;
        bit            ov, ewen, ff;
        int            p;
        if (!rnd_mode) drive();
        #1;
        eg   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        ov   = (m_owner >= 0) && (((req_valid >> m_owner) & 1) != 0);
        ewen = ov && !fifo_full;
        ed   = (m_owner >= 0) ? DW'(req_data >> (m_owner * DW)) : '0;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("w_en", 32'(fifo_w_en), 32'(ewen));
        chk("ready", 32'(req_ready), 32'(fifo_full ? '0 : eg));
        chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        if (fifo_full) chk("no_write_full", 32'(fifo_w_en), 32'd0);
        if (ewen) chk("w_data", 32'(fifo_w_data), 32'(ed));
        if (grant !== prev_g && grant != '0) order_q.push_back(grant);
        prev_g = grant;
        if (fifo_w_en) begin
            got_q.push_back(fifo_w_data);
            for (int i = 0; i < N; i++) if (grant[i]) dut_w[i]++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        vv = req_valid;
        ff = fifo_full;
        @(posedge clk);
        if (m_owner < 0) begin
            p = rr_first(vv, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_words = 0;
            end
        end else begin
            if (ewen) begin
                exp_q.push_back(ed);
                m_acc[m_owner]++;
                seq[m_owner]++;
                left[m_owner]--;
                m_words++;
            end
            if ((ewen && m_words == MAXB) || !ov) begin
                m_ptr   = (m_owner + 1) % N;
                m_words = 0;
                m_owner = rr_first(vv, m_ptr);
            end
        end
        if (ff) begin end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_w_en", 32'(fifo_w_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; dut_w[i] = 0; seq[i] = 0; left[i] = 0;
        end
        en = '0;
        model_reset();
        #2;
        do_reset();

        // Single producer 0, six words: burst of four then a seamless re-grant to itself.
        en = 4'b0001; left[0] = 6;
        for (int s = 0; s < 5; s++) step();
        chk("t1_regrant_self", 32'(grant), 32'b0001);
        for (int s = 0; s < 3; s++) step();
        chk("t1_words", 32'(dut_w[0]), 32'd6);
        chk("t1_no_bubble", 32'(max_run), 32'd6);

        // All producers valid from rr_ptr=0: strict order 0,1,2,3,0 with four words each.
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < N; i++) begin left[i] = 100; dut_w[i] = 0; end
        for (int s = 0; s < 21; s++) step();
        chk("t2_order_len", 32'(order_q.size()), 32'd5);
        if (order_q.size() == 5) begin
            chk("t2_order0", 32'(order_q[0]), 32'b0001);
            chk("t2_order1", 32'(order_q[1]), 32'b0010);
            chk("t2_order2", 32'(order_q[2]), 32'b0100);
            chk("t2_order3", 32'(order_q[3]), 32'b1000);
            chk("t2_order4", 32'(order_q[4]), 32'b0001);
        end
        chk("t2_p0", 32'(dut_w[0]), 32'd8);
        chk("t2_p1", 32'(dut_w[1]), 32'd4);
        chk("t2_p3", 32'(dut_w[3]), 32'd4);
        chk("t2_no_idle", 32'(max_run), 32'd20);

        // Producer 1 owns; FIFO full for three cycles mid-burst.
        do_reset();
        en = 4'b0010;
        for (int i = 0; i < N; i++) begin left[i] = 0; dut_w[i] = 0; end
        left[1] = 8;
        for (int s = 0; s < 3; s++) step();
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) step();
        chk("t3_grant_held", 32'(grant), 32'b0010);
        chk("t3_words_frozen", 32'(dut_w[1]), 32'd2);
        fifo_full = 1'b0;
        for (int s = 0; s < 6; s++) step();
        chk("t3_words_total", 32'(dut_w[1]), 32'd8);

        // Producer 2 drops valid after two words; producer 3 takes over.
        do_reset();
        en = 4'b1100;
        for (int i = 0; i < N; i++) begin left[i] = 0; dut_w[i] = 0; end
        left[2] = 2; left[3] = 10;
        for (int s = 0; s < 4; s++) step();
        chk("t4_handover", 32'(grant), 32'b1000);
        for (int s = 0; s < 4; s++) step();
        chk("t4_p2_words", 32'(dut_w[2]), 32'd2);
        chk("t4_p3_words", 32'(dut_w[3]), 32'd4);

        // Asynchronous reset between edges while producer 1 owns the port.
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < N; i++) left[i] = 100;
        for (int s = 0; s < 6; s++) step();
        chk("t5_pre_grant", 32'(grant), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_w_en", 32'(fifo_w_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int s = 0; s < 2; s++) step();
        chk("t5_restart_p0", 32'(grant), 32'b0001);

        // Randomized valid, data and full patterns.
        rnd_mode = 1;
        for (int s = 0; s < 400; s++) begin
            req_valid = N'($urandom) | N'($urandom);
            req_data  = (N*DW)'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            step();
        end
        rnd_mode  = 0;
        fifo_full = 1'b0;

`ifdef FIFO_ARB_STATS_EN
        // Accepted-word counters over 32 back-to-back writes: eight per producer.
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < N; i++) left[i] = 100;
        for (int s = 0; s < 33; s++) step();
        for (int i = 0; i < N; i++) chk("t6_stat", 32'(stat_count[i*16 +: 16]), 32'd8);
`endif

        // Every model-predicted word reached the FIFO, in order.
        chk("sb_size", 32'(got_q.size()), 32'(exp_q.size()));
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) chk("sb_word", 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
